fft_power_serializer: RTL

FFT_POWER_SERIALIZER -- requirements
Module: fft_power_serializer

---
 rtl/fft_power_serializer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fft_power_serializer.sv
// fft_power_serializer
// Captures one pair of complex DFT bins on each rising edge of the core's
// level-style result-valid, squares and sums them into power words, then
// scales and saturates them. Pairs are queued in a small FIFO and streamed out
// one word at a time: bin 1 first, then bin 2 with m_last set.
module fft_power_serializer #(
  parameter int S_WIDTH   = 32,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 16,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        res_valid_i,
  input  logic signed [S_WIDTH-1:0]   re1,
  input  logic signed [S_WIDTH-1:0]   im1,
  input  logic signed [S_WIDTH-1:0]   re2,
  input  logic signed [S_WIDTH-1:0]   im2,
  output logic [OUT_WIDTH-1:0]        m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic                        overflow_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int PW = 2 * S_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = (PW > OUT_WIDTH) ? PW : OUT_WIDTH;

  typedef enum logic {
    PH_BIN1 = 1'b0,
    PH_BIN2 = 1'b1
  } phase_t;

  // Exact square: sign-extend to 2*S_WIDTH first so that the most negative
  // input squares to 2^(2*S_WIDTH-2) without wrapping.
  function automatic logic [PW-1:0] square(input logic signed [S_WIDTH-1:0] x);
    logic signed [PW-1:0] xe;
    xe = $signed({{S_WIDTH{x[S_WIDTH-1]}}, x});
    return $unsigned(xe * xe);
  endfunction

  // Shift the power down and clamp it to the output word. The comparison is
  // done in a width wide enough for both the power and the output word.
  function automatic logic [OUT_WIDTH-1:0] scale(input logic [PW-1:0] p);
    logic [PW-1:0] sh;
    logic [EW-1:0] ext;
    sh  = p >> SHIFT;
    ext = EW'(sh);
    if (ext > EW'({OUT_WIDTH{1'b1}})) return '1;
    return ext[OUT_WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------- capture
  logic res_prev;
  logic strobe;

  assign strobe = res_valid_i & ~res_prev;

  // Previous-value flag for rising-edge detection of the result-valid level.
  always_ff @(posedge clk) begin
    if (rst) res_prev <= 1'b0;
    else     res_prev <= res_valid_i;
  end

  // ---------------------------------------------------------------- stage A
  logic                      a_valid;
  logic signed [S_WIDTH-1:0] a_re1, a_im1, a_re2, a_im2;

  // Stage A valid: one cycle after each capture strobe.
  always_ff @(posedge clk) begin
    if (rst) a_valid <= 1'b0;
    else     a_valid <= strobe;
  end

  // Stage A data: hold the bins sampled on the strobe.
  always_ff @(posedge clk) begin
    if (strobe) begin
      a_re1 <= re1;
      a_im1 <= im1;
      a_re2 <= re2;
      a_im2 <= im2;
    end
  end

  // ---------------------------------------------------------------- stage B
  logic          b_valid;
  logic [PW-1:0] b_sq_re1, b_sq_im1, b_sq_re2, b_sq_im2;

  // Stage B valid follows stage A.
  always_ff @(posedge clk) begin
    if (rst) b_valid <= 1'b0;
    else     b_valid <= a_valid;
  end

  // Stage B data: the four squares.
  always_ff @(posedge clk) begin
    if (a_valid) begin
      b_sq_re1 <= square(a_re1);
      b_sq_im1 <= square(a_im1);
      b_sq_re2 <= square(a_re2);
      b_sq_im2 <= square(a_im2);
    end
  end

  // ---------------------------------------------------------------- stage C
  // Each square is at most 2^(PW-2), so the sum fits PW bits.
  logic [PW-1:0]        pwr1, pwr2;
  logic [OUT_WIDTH-1:0] word1, word2;

  // Sum, scale and saturate both bins.
  always_comb begin
    pwr1  = b_sq_re1 + b_sq_im1;
    pwr2  = b_sq_re2 + b_sq_im2;
    word1 = scale(pwr1);
    word2 = scale(pwr2);
  end

  // ---------------------------------------------------------------- FIFO
  logic [OUT_WIDTH-1:0] mem_b1 [DEPTH];
  logic [OUT_WIDTH-1:0] mem_b2 [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count, count_n;
  phase_t               phase, phase_n;
  logic                 ovf;
  logic                 full, empty, accept, pop, wr_en, drop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign accept = ~empty & m_ready;
  assign pop    = accept & (phase == PH_BIN2);
  // A full FIFO still takes the pair if the head pair leaves this same cycle.
  assign wr_en  = b_valid & (~full | pop);
  assign drop   = b_valid & full & ~pop;

  // Next read phase and occupancy.
  always_comb begin
    phase_n = phase;
    count_n = count;
    if (accept) phase_n = (phase == PH_BIN1) ? PH_BIN2 : PH_BIN1;
    unique case ({wr_en, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  // FIFO storage; contents need no reset since reads are gated by count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_b1[wr_ptr] <= word1;
      mem_b2[wr_ptr] <= word2;
    end
  end

  // FIFO control: pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      phase  <= PH_BIN1;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (drop)  ovf    <= 1'b1;
      count <= count_n;
      phase <= phase_n;
    end
  end

  // ---------------------------------------------------------------- output
  // Output word selection; data and last are forced low when nothing is held.
  always_comb begin
    m_valid    = ~empty;
    m_last     = ~empty & (phase == PH_BIN2);
    m_data     = '0;
    if (~empty) m_data = (phase == PH_BIN2) ? mem_b2[rd_ptr] : mem_b1[rd_ptr];
    overflow_o = ovf;
    count_o    = count;
  end

endmodule
